// File: rtl/l2_cache_control_nway.sv
// l2_cache_control_nway: N-way set-associative L2 controller with tree-PLRU, write-back and perf counters
module l2_cache_control_nway #(
  parameter int WAYS = 4,
  parameter int S_OFFSET = 5,
  parameter int S_INDEX = 3,
  localparam int TAG_W = 32 - S_INDEX - S_OFFSET,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mem_address,
  input  logic                  l2_read,
  input  logic                  l2_write,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  input  logic [WAYS*TAG_W-1:0] tag_out,
  input  logic [WAYS-1:0]       valid_out,
  input  logic [WAYS-1:0]       dirty_out,
  input  logic [WAYS-2:0]       plru_out,
  output logic [WAYS-1:0]       tag_ld,
  output logic [WAYS-1:0]       valid_ld,
  output logic [WAYS-1:0]       dirty_ld,
  output logic [WAYS-1:0]       data_we,
  output logic                  valid_in,
  output logic                  dirty_in,
  output logic                  plru_ld,
  output logic [WAYS-2:0]       plru_in,
  output logic                  data_in_select,
  output logic [WAY_W-1:0]      out_way,
  output logic                  pmem_addr_select,
  input  logic                  perf_clear,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
);
  localparam int PW = WAYS - 1;
  typedef enum logic [1:0] {DECODE, WRITE_BACK, ALLOCATE} state_t;
  state_t state, state_n;
  logic [WAY_W-1:0] victim, victim_sel, hit_way, inv_way, plru_way;
  logic [WAYS-1:0] hit_oh, vic_oh;
  logic [TAG_W-1:0] tag;
  logic hit, any_inv, req, retry, miss;
  logic unused_addr;
  assign tag = mem_address[31 -: TAG_W];
  assign unused_addr = ^mem_address[31-TAG_W:0];
  assign req = l2_read ^ l2_write;
  assign hit_oh = WAYS'(1) << hit_way;
  assign vic_oh = WAYS'(1) << victim;
  assign victim_sel = any_inv ? inv_way : plru_way;
  assign miss = state == DECODE && req && !hit;

  function automatic logic [31:0] bump(input logic [31:0] c, input logic inc);
    return (inc && ~&c) ? c + 32'd1 : c;
  endfunction

  // Tag compare, lowest invalid way and PLRU victim walk for the addressed set
  always_comb begin
    int node;
    logic [PW-1:0] sh;
    hit = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid_out[i] && tag_out[i*TAG_W +: TAG_W] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!valid_out[i]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(i);
      end
    end
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sh = plru_out >> node;
      node = sh[0] ? 2 * node + 2 : 2 * node + 1;
    end
    plru_way = WAY_W'(node - PW);
  end

  // PLRU update: every node on the hit way's path points away from it
  always_comb begin
    int node;
    logic [WAY_W-1:0] hs;
    plru_in = plru_out;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      hs = hit_way >> (WAY_W - 1 - l);
      plru_in = (plru_in & ~(PW'(1) << node)) | (PW'(!hs[0]) << node);
      node = 2 * node + 1 + int'(hs[0]);
    end
  end

  // Next state and array/pmem controls; everything is held low during reset
  always_comb begin
    state_n = state;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    tag_ld = '0;
    valid_ld = '0;
    dirty_ld = '0;
    data_we = '0;
    valid_in = 1'b0;
    dirty_in = 1'b0;
    plru_ld = 1'b0;
    data_in_select = 1'b0;
    out_way = '0;
    pmem_addr_select = 1'b0;
    if (!rst)
      case (state)
        DECODE: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            out_way = hit_way;
            plru_ld = 1'b1;
            if (l2_write) begin
              data_we = hit_oh;
              tag_ld = hit_oh;
              dirty_ld = hit_oh;
              dirty_in = 1'b1;
            end
          end else if (req)
            state_n = (valid_out[victim_sel] && dirty_out[victim_sel]) ? WRITE_BACK : ALLOCATE;
        end
        WRITE_BACK: begin
          pmem_write = 1'b1;
          pmem_addr_select = 1'b1;
          out_way = victim;
          state_n = pmem_resp ? ALLOCATE : WRITE_BACK;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          data_in_select = 1'b1;
          out_way = victim;
          data_we = vic_oh;
          tag_ld = vic_oh;
          valid_ld = vic_oh;
          dirty_ld = vic_oh;
          valid_in = 1'b1;
          state_n = pmem_resp ? DECODE : ALLOCATE;
        end
        default: state_n = DECODE;
      endcase
  end

  // State, latched victim and post-allocate retry flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DECODE;
      victim <= '0;
      retry <= 1'b0;
    end else begin
      state <= state_n;
      victim <= miss ? victim_sel : victim;
      retry <= (state == ALLOCATE && pmem_resp) ? 1'b1 : mem_resp ? 1'b0 : retry;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || perf_clear) begin
      hit_count <= '0;
      miss_count <= '0;
      wb_count <= '0;
    end else begin
      hit_count <= bump(hit_count, mem_resp && !retry);
      miss_count <= bump(miss_count, miss);
      wb_count <= bump(wb_count, state == WRITE_BACK && pmem_resp);
    end
  end
endmodule

// File: tb/tb_l2_cache_control_nway.sv
// tb_l2_cache_control_nway: directed checks of the 4-way L2 controller
module tb_l2_cache_control_nway;
  logic clk = 1'b0;
  logic rst, l2_read, l2_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [31:0] mem_address, hit_count, miss_count, wb_count;
  logic [95:0] tag_out;
  logic [3:0] valid_out, dirty_out, tag_ld, valid_ld, dirty_ld, data_we;
  logic [2:0] plru_out, plru_in;
  logic valid_in, dirty_in, plru_ld, data_in_select, pmem_addr_select, perf_clear;
  logic [1:0] out_way;
  int n_cmp = 0, n_bad = 0;

  l2_cache_control_nway dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .l2_read(l2_read), .l2_write(l2_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .tag_out(tag_out), .valid_out(valid_out), .dirty_out(dirty_out), .plru_out(plru_out),
    .tag_ld(tag_ld), .valid_ld(valid_ld), .dirty_ld(dirty_ld), .data_we(data_we),
    .valid_in(valid_in), .dirty_in(dirty_in), .plru_ld(plru_ld), .plru_in(plru_in),
    .data_in_select(data_in_select), .out_way(out_way), .pmem_addr_select(pmem_addr_select),
    .perf_clear(perf_clear), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic counts(input logic [31:0] h, input logic [31:0] m, input logic [31:0] w);
    chk("hit_count", hit_count, h);
    chk("miss_count", miss_count, m);
    chk("wb_count", wb_count, w);
  endtask

  // Present a read/write that must hit way w and check the PLRU update
  task automatic hit_chk(input logic wr, input logic [23:0] t, input logic [2:0] pl,
                         input logic [1:0] w, input logic [2:0] pin);
    l2_read = !wr;
    l2_write = wr;
    mem_address = {t, 8'h00};
    plru_out = pl;
    #1;
    chk("hit_resp", mem_resp, 1);
    chk("hit_way", out_way, w);
    chk("hit_plru_ld", plru_ld, 1);
    chk("hit_plru_in", plru_in, pin);
    if (wr) begin
      chk("wr_data_we", data_we, 4'b1 << w);
      chk("wr_dirty_ld", dirty_ld, 4'b1 << w);
      chk("wr_tag_ld", tag_ld, 4'b1 << w);
      chk("wr_dirty_in", dirty_in, 1);
      chk("wr_data_sel", data_in_select, 0);
    end
    @(negedge clk);
    l2_read = 1'b0;
    l2_write = 1'b0;
  endtask

  // Read miss on tag t; optional write-back, then a one-cycle allocate into way w
  task automatic miss_chk(input logic [23:0] t, input logic wb, input logic [1:0] w);
    l2_read = 1'b1;
    mem_address = {t, 8'h00};
    #1;
    chk("miss_no_resp", mem_resp, 0);
    @(negedge clk);
    if (wb) begin
      #1;
      chk("wb_pmem_write", pmem_write, 1);
      chk("wb_addr_sel", pmem_addr_select, 1);
      chk("wb_out_way", out_way, w);
      chk("wb_no_read", pmem_read, 0);
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    #1;
    chk("alloc_pmem_read", pmem_read, 1);
    chk("alloc_no_write", pmem_write, 0);
    chk("alloc_data_we", data_we, 4'b1 << w);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    l2_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    l2_read = 1'b1;
    l2_write = 1'b0;
    mem_address = {24'hABC, 8'h00};
    pmem_resp = 1'b0;
    tag_out = '0;
    valid_out = '0;
    dirty_out = '0;
    plru_out = '0;
    perf_clear = 1'b0;
    #1;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    l2_read = 1'b0;
    #1;
    counts(0, 0, 0);
    // cold read miss: victim way 0, held allocate ignores valid_out change
    l2_read = 1'b1;
    #1;
    chk("cold_no_resp", mem_resp, 0);
    chk("cold_no_pmem", pmem_read, 0);
    @(negedge clk);
    #1;
    chk("cold_pmem_read", pmem_read, 1);
    chk("cold_data_we", data_we, 4'b0001);
    chk("cold_tag_ld", tag_ld, 4'b0001);
    chk("cold_valid_ld", valid_ld, 4'b0001);
    chk("cold_dirty_ld", dirty_ld, 4'b0001);
    chk("cold_valid_in", valid_in, 1);
    chk("cold_dirty_in", dirty_in, 0);
    chk("cold_data_sel", data_in_select, 1);
    valid_out = 4'b0001;
    #1;
    chk("victim_latched", data_we, 4'b0001);
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("alloc_hold", pmem_read, 1);
    @(negedge clk);
    pmem_resp = 1'b0;
    tag_out[23:0] = 24'hABC;
    #1;
    chk("retry_resp", mem_resp, 1);
    chk("retry_way", out_way, 0);
    chk("retry_no_pmem", pmem_read, 0);
    @(negedge clk);
    l2_read = 1'b0;
    #1;
    counts(0, 1, 0);
    // full set hits and PLRU updates
    tag_out = {24'h00000D, 24'h00000C, 24'h00000B, 24'h00000A};
    valid_out = 4'b1111;
    hit_chk(0, 24'hA, 3'b000, 0, 3'b011);
    chk("first_hit_count", hit_count, 1);
    hit_chk(0, 24'hD, 3'b111, 3, 3'b010);
    hit_chk(0, 24'hB, 3'b000, 1, 3'b001);
    hit_chk(0, 24'hC, 3'b111, 2, 3'b110);
    counts(4, 1, 0);
    // invalid way preferred over PLRU victim, even when others are dirty
    valid_out = 4'b1011;
    dirty_out = 4'b1111;
    plru_out = 3'b000;
    miss_chk(24'hF, 0, 2);
    tag_out[71:48] = 24'hF;
    valid_out = 4'b1111;
    hit_chk(0, 24'hF, 3'b000, 2, 3'b100);
    // clean PLRU victim
    dirty_out = 4'b0000;
    plru_out = 3'b101;
    miss_chk(24'h10, 0, 3);
    tag_out[95:72] = 24'h10;
    hit_chk(0, 24'h10, 3'b101, 3, 3'b000);
    // dirty PLRU victim with write-back
    dirty_out = 4'b1111;
    plru_out = 3'b000;
    miss_chk(24'hE, 1, 0);
    tag_out[23:0] = 24'hE;
    dirty_out = 4'b0000;
    hit_chk(0, 24'hE, 3'b000, 0, 3'b011);
    counts(4, 4, 1);
    // write hit on way 2 (tag 0xF)
    hit_chk(1, 24'hF, 3'b000, 2, 3'b100);
    counts(5, 4, 1);
    // both strobes high: no request
    l2_read = 1'b1;
    l2_write = 1'b1;
    mem_address = {24'h77, 8'h00};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("both_no_resp", mem_resp, 0);
      chk("both_no_read", pmem_read, 0);
      chk("both_no_write", pmem_write, 0);
      @(negedge clk);
    end
    l2_read = 1'b0;
    l2_write = 1'b0;
    #1;
    counts(5, 4, 1);
    // reset in the middle of an allocate
    valid_out = 4'b0000;
    l2_read = 1'b1;
    mem_address = {24'h55, 8'h00};
    @(negedge clk);
    #1;
    chk("pre_rst_read", pmem_read, 1);
    rst = 1'b1;
    #1;
    chk("rst_drop_read", pmem_read, 0);
    chk("rst_drop_we", data_we, 0);
    @(negedge clk);
    rst = 1'b0;
    l2_read = 1'b0;
    #1;
    chk("post_rst_idle", pmem_read, 0);
    counts(0, 0, 0);
    valid_out = 4'b1111;
    hit_chk(0, 24'hE, 3'b000, 0, 3'b011);
    chk("post_rst_hit", hit_count, 1);
    // saturation and clear priority
    force dut.hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count;
    hit_chk(0, 24'hE, 3'b000, 0, 3'b011);
    chk("hit_saturate", hit_count, 32'hFFFF_FFFF);
    perf_clear = 1'b1;
    hit_chk(0, 24'hE, 3'b000, 0, 3'b011);
    perf_clear = 1'b0;
    #1;
    chk("clear_over_hit", hit_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
